// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the EX stage: owns HI/LO,
// sequences mult/multu/div/divu over a fixed latency and handles mthi/mtlo.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pending_hi, pending_lo;
    logic        pending_we;
    logic        accept, commit;

    // Datapath: both products and a magnitude-based divide, selected by op.
    logic [63:0] prod_s, prod_u, result;
    logic        sdiv;
    logic [31:0] dvd, dvs, dvs_safe, q_u, r_u, quo, rem;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Dividing magnitudes keeps 0x80000000 / -1 well defined (q wraps to 0x80000000).
    assign sdiv     = (op == 3'd2);
    assign dvd      = (sdiv && a[31]) ? -a : a;
    assign dvs      = (sdiv && b[31]) ? -b : b;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign q_u      = dvd / dvs_safe;
    assign r_u      = dvd % dvs_safe;
    assign quo      = (sdiv && (a[31] ^ b[31])) ? -q_u : q_u;
    assign rem      = (sdiv && a[31]) ? -r_u : r_u;

    always_comb begin
        case (op)
            3'd0:    result = prod_s;
            3'd1:    result = prod_u;
            default: result = {rem, quo};
        endcase
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (op <= 3'd3)) begin
                    accept  = 1'b1;
                    cnt_d   = op[1] ? DIV_LOAD : MULT_LOAD;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_we <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pending_hi <= result[63:32];
                pending_lo <= result[31:0];
                // Divide by zero still runs the full latency but leaves HI/LO alone.
                pending_we <= !(op[1] && (b == 32'd0));
            end
            if (commit && pending_we) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end else if (state_q == IDLE && start && op == 3'd4) begin
                hi <= a;
            end else if (state_q == IDLE && start && op == 3'd5) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO pushed at issue, popped and
// compared when busy drops; latency, hold and reset behaviour also checked.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    logic [63:0] sb_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = $signed(ma);
        sb = $signed(mb);
        ua = {32'b0, ma};
        ub = {32'b0, mb};
        case (mop)
            3'd0: model = 64'(sa * sb);
            3'd1: model = ua * ub;
            3'd2: begin
                if (mb == 32'd0) model = {exp_hi, exp_lo};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (mb == 32'd0) model = {exp_hi, exp_lo};
                else model = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Caller is always #1 after a rising edge; the op is sampled at the next edge.
    task automatic run_md(input string tag, input logic [2:0] mop, input logic [31:0] ma,
                          input logic [31:0] mb, input int n, input bit poke);
        int cycles;
        logic [63:0] want;
        start = 1'b1; op = mop; a = ma; b = mb;
        sb_q.push_back(model(mop, ma, mb));
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            check({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
            a = $urandom; b = $urandom;
            if (poke && cycles == 2) begin
                start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check({tag, "_busy_len"}, 64'(cycles), 64'(n));
        want = sb_q.pop_front();
        check({tag, "_hilo"}, {hi, lo}, want);
        exp_hi = want[63:32];
        exp_lo = want[31:0];
    endtask

    task automatic write_hl(input string tag, input logic [2:0] mop, input logic [31:0] ma);
        start = 1'b1; op = mop; a = ma;
        @(posedge clk); #1;
        start = 1'b0;
        if (mop == 3'd4) exp_hi = ma;
        if (mop == 3'd5) exp_lo = ma;
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_md("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 1'b0);
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_md("divu", 3'd3, 32'd100, 32'd7, 10, 1'b0);
        run_md("div_mix", 3'd2, 32'd17, 32'hFFFF_FFFB, 10, 1'b0);

        write_hl("mthi", 3'd4, 32'h1234_5678);
        write_hl("mtlo", 3'd5, 32'h9ABC_DEF0);
        write_hl("rsvd6", 3'd6, 32'h5555_5555);

        write_hl("mthi5", 3'd4, 32'd5);
        write_hl("mtlo7", 3'd5, 32'd7);
        run_md("divu_b0", 3'd3, 32'd99, 32'd0, 10, 1'b1);
        check("divu_b0_const", {hi, lo}, 64'h0000_0005_0000_0007);

        // Back-to-back: a div then a mult with no idle cycle between them.
        run_md("b2b_div", 3'd3, 32'hFFFF_0000, 32'd3, 10, 1'b0);
        run_md("b2b_mult", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 5, 1'b0);

        // Abort a running div with reset during its fourth busy cycle.
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort_running", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_late", {hi, lo}, 64'd0);
        check("abort_idle", {63'b0, busy}, 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        run_md("post_reset", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline, instantiated in the EX stage beside the ALU.
- Owns the architectural HI/LO registers and sequences mult/multu/div/divu over a fixed number of cycles.
- Raises `busy` while an operation runs. The hazard unit combines `busy` and `start` with decoded mfhi/mflo/md instructions to stall D/E.
- Handles mthi/mtlo single-cycle writes.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  EX-stage md instruction valid this cycle (qualified by pipeline, not flushed)
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved (no-op)
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- busy  output  1  operation in progress
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (sync, active-high): hi=0, lo=0, busy=0, counter=0, pending result regs=0. Reset mid-operation aborts the op; no HI/LO update ever lands from it.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter active).
- IDLE, start=1, op in {0..3}, at edge T:
  - Compute the result from a/b and latch it into pending_hi/pending_lo.
  - Load counter with N-1, where N=MULT_CYCLES for op 0/1 and DIV_CYCLES for op 2/3.
  - Go to RUN.
  - busy is high for exactly N cycles after edge T.
- RUN, each edge:
  - counter!=0: decrement.
  - counter==0: hi<=pending_hi, lo<=pending_lo, go to IDLE; busy low after this edge (edge T+N).
- hi/lo keep their old values throughout RUN. New values are visible combinationally from edge T+N onward.
- IDLE, start=1, op=4: hi<=a at the edge, no busy. op=5: lo<=a at the edge, no busy. Ops 6/7: no effect.
- start=1 while busy=1 (any op): ignored entirely. The pipeline guarantees this by stalling; the bench asserts nothing changes.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product, {hi,lo}=product.
  - multu: unsigned 32x32 -> 64-bit product, {hi,lo}=product.
  - div: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - b==0 for div/divu: full N-cycle busy sequence still runs, but hi/lo are left unchanged at completion.
- Operands are sampled only at the start edge. Changes on a/b during RUN have no effect.
- MULT_CYCLES=1 or DIV_CYCLES=1: busy high for exactly one cycle, result lands at edge T+1.
- Reset overrides start in the same cycle.
- Back-to-back: start in the first cycle busy=0 after completion is accepted normally; no dead cycle.

Test Plan:
1. Reset, then mult with a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; at completion hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo stay 0 during busy.
2. multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
3. div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> busy never asserts; hi=0x12345678, lo=0x9ABCDEF0 one edge after each.
5. divu with b=0 after hi=5, lo=7 -> busy 10 cycles, hi=5, lo=7 retained. Issue mthi during busy -> ignored.
6. Start div, assert reset at busy cycle 4 -> next edge busy=0, hi=lo=0, no late update. Also a mult accepted in the cycle after a completion produces correct results with no gap.
